// File: rtl/cw305_ml_sched_if.sv
// rtl/cw305_ml_sched_if.sv - register-block to dense-layer sequencer handshake and operand bus
interface cw305_ml_sched_if #(
    parameter int pINPUTCNT  = 4,
    parameter int pOUTPUTCNT = 4
);
    logic                                 start_i;
    logic [pINPUTCNT*8-1:0]               inputs_i;
    logic [pINPUTCNT*pOUTPUTCNT*8-1:0]    weights_i;
    logic [pOUTPUTCNT*8-1:0]              bias_i;
    logic                                 busy_o;
    logic                                 done_o;
    logic [pOUTPUTCNT*8-1:0]              outputs_o;
    logic                                 trigger_o;

    modport master (
        output start_i, inputs_i, weights_i, bias_i,
        input  busy_o, done_o, outputs_o, trigger_o
    );

    modport slave (
        input  start_i, inputs_i, weights_i, bias_i,
        output busy_o, done_o, outputs_o, trigger_o
    );
endinterface

// File: rtl/cw305_ml_sched.sv
// rtl/cw305_ml_sched.sv - dense-layer MAC/ReLU/saturate sequencer sharing one 8x8 multiplier
// Optional SCA capture trigger over MAC cycles: define CW305_ML_SCHED_TRIGGER_EN.
module cw305_ml_sched #(
    parameter int pINPUTCNT  = 4,
    parameter int pOUTPUTCNT = 4,
    parameter int pFRAC      = 4
) (
    input  logic                   usb_clk,
    input  logic                   reset_i,
    cw305_ml_sched_if.slave        bus
);
    localparam int ACCW = 16 + $clog2(pINPUTCNT) + pFRAC + 1;
    localparam int IW   = (pINPUTCNT  > 1) ? $clog2(pINPUTCNT)  : 1;
    localparam int OW   = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, ACT, DONE} state_t;

    state_t                              state;
    logic [pINPUTCNT*8-1:0]              in_q;
    logic [pINPUTCNT*pOUTPUTCNT*8-1:0]   weights_q;
    logic [pOUTPUTCNT*8-1:0]             bias_q;
    logic [pOUTPUTCNT*8-1:0]             shadow_q;
    logic [pOUTPUTCNT*8-1:0]             outputs_q;
    logic signed [ACCW-1:0]              acc;
    logic [IW-1:0]                       i_cnt;
    logic [OW-1:0]                       o_cnt;
    logic                                busy_q;
    logic                                done_q;

    logic signed [7:0]                   in_sel;
    logic signed [7:0]                   w_sel;
    logic signed [7:0]                   b_sel;
    logic signed [15:0]                  prod;
    logic signed [ACCW-1:0]              shifted;
    logic [7:0]                          res;
    logic                                last_i;
    logic                                last_o;

    assign in_sel = in_q[8*int'(i_cnt) +: 8];
    assign w_sel  = weights_q[8*(int'(o_cnt)*pINPUTCNT + int'(i_cnt)) +: 8];
    assign b_sel  = bias_q[8*int'(o_cnt) +: 8];
    assign prod   = in_sel * w_sel;
    assign last_i = (i_cnt == IW'(pINPUTCNT - 1));
    assign last_o = (o_cnt == OW'(pOUTPUTCNT - 1));

    // ReLU clamps negatives to 0; positives saturate to the int8 maximum.
    always_comb begin
        shifted = acc >>> pFRAC;
        res     = shifted[7:0];
        if (shifted < 0)
            res = 8'd0;
        else if (shifted > ACCW'(127))
            res = 8'd127;
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            in_q      <= '0;
            weights_q <= '0;
            bias_q    <= '0;
            shadow_q  <= '0;
            outputs_q <= '0;
            acc       <= '0;
            i_cnt     <= '0;
            o_cnt     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // busy trails the state by one edge so it spans edge 1 through the DONE cycle
            busy_q <= (state != IDLE);
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // done_q is high in the first IDLE cycle; a start there belongs to DONE
                    if (bus.start_i && !done_q) begin
                        in_q      <= bus.inputs_i;
                        weights_q <= bus.weights_i;
                        bias_q    <= bus.bias_i;
                        o_cnt     <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= {{(ACCW-8-pFRAC){b_sel[7]}}, b_sel, {pFRAC{1'b0}}};
                    i_cnt <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc + {{(ACCW-16){prod[15]}}, prod};
                    if (last_i)
                        state <= ACT;
                    else
                        i_cnt <= i_cnt + IW'(1);
                end
                ACT: begin
                    shadow_q[8*int'(o_cnt) +: 8] <= res;
                    if (last_o) begin
                        state <= DONE;
                    end else begin
                        o_cnt <= o_cnt + OW'(1);
                        state <= LOAD;
                    end
                end
                DONE: begin
                    outputs_q <= shadow_q;
                    done_q    <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.outputs_o = outputs_q;

`ifdef CW305_ML_SCHED_TRIGGER_EN
    logic trigger_q;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i)
            trigger_q <= 1'b0;
        else
            trigger_q <= (state == LOAD) || ((state == MAC) && !last_i);
    end

    assign bus.trigger_o = trigger_q;
`else
    assign bus.trigger_o = 1'b0;
`endif
endmodule

// File: tb/tb_cw305_ml_sched.sv
// tb/tb_cw305_ml_sched.sv - scoreboard bench for cw305_ml_sched against an arithmetic reference model
module tb_cw305_ml_sched;
    localparam int NI   = 4;
    localparam int NO   = 4;
    localparam int FRAC = 4;
`ifdef CW305_ML_SCHED_TRIGGER_EN
    localparam int EXP_TRIG = NI * NO;
`else
    localparam int EXP_TRIG = 0;
`endif

    logic usb_clk = 1'b0;
    logic reset_i = 1'b1;

    cw305_ml_sched_if #(.pINPUTCNT(NI), .pOUTPUTCNT(NO)) bus ();

    cw305_ml_sched #(.pINPUTCNT(NI), .pOUTPUTCNT(NO), .pFRAC(FRAC)) dut (
        .usb_clk (usb_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 usb_clk = ~usb_clk;

    int               cyc = 0;
    int               s = -1000;
    bit               run_active = 0;
    int               trig_cnt = 0;
    int               vectors = 0;
    int               miscompares = 0;
    logic [NO*8-1:0]  hold_val = '0;
    logic [NO*8-1:0]  exp_q[$];

    always @(posedge usb_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: bias scaled by 2^FRAC plus dot product, floor-shift, clamp to [0,127].
    function automatic logic [NO*8-1:0] model(input logic [NI*8-1:0] in,
                                              input logic [NI*NO*8-1:0] w,
                                              input logic [NO*8-1:0] b);
        logic [NO*8-1:0] r_all;
        for (int o = 0; o < NO; o++) begin
            int acc;
            int r;
            int bv;
            bv  = $signed(b[8*o +: 8]);
            acc = bv * (1 << FRAC);
            for (int i = 0; i < NI; i++) begin
                int a;
                int c;
                a = $signed(in[8*i +: 8]);
                c = $signed(w[8*(o*NI+i) +: 8]);
                acc = acc + a * c;
            end
            r = acc >>> FRAC;
            if (r < 0) r = 0;
            if (r > 127) r = 127;
            r_all[8*o +: 8] = r[7:0];
        end
        return r_all;
    endfunction

    // Monitor: busy window, done timing, published results and trigger count.
    always @(negedge usb_clk) begin
        int k;
        k = cyc - s;
        if (reset_i) begin
            trig_cnt = 0;
        end else begin
            if (bus.trigger_o === 1'b1) trig_cnt++;
            chk("busy", 64'(bus.busy_o), 64'(run_active && k >= 1 && k <= 25));
            chk("done", 64'(bus.done_o), 64'(run_active && k == 25));
            if (bus.done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(exp_q.size()), 64'd1);
                end else begin
                    hold_val = exp_q.pop_front();
                    chk("trigger_cnt", 64'(trig_cnt), 64'(EXP_TRIG));
                end
                trig_cnt = 0;
            end
            chk("outputs", 64'(bus.outputs_o), 64'(hold_val));
        end
    end

    // mode 0 normal, 1 snapshot/restart disturbance, 2 reset at cycle 12, 3 start during done
    task automatic do_run(input logic [NI*8-1:0] in, input logic [NI*NO*8-1:0] w,
                          input logic [NO*8-1:0] b, input int mode);
        bus.inputs_i  = in;
        bus.weights_i = w;
        bus.bias_i    = b;
        @(posedge usb_clk); #1 bus.start_i = 1'b1;
        @(posedge usb_clk); #1 bus.start_i = 1'b0;
        s = cyc;
        run_active = 1;
        exp_q.push_back(model(in, w, b));
        for (int k = 1; k <= 28; k++) begin
            @(posedge usb_clk); #1;
            if (mode == 1 && k == 5) bus.weights_i = ~bus.weights_i;
            if (mode == 1 && k == 9) bus.start_i = 1'b1;
            if (mode == 1 && k == 10) bus.start_i = 1'b0;
            if (mode == 3 && k == 25) bus.start_i = 1'b1;
            if (mode == 3 && k == 26) bus.start_i = 1'b0;
            if (mode == 2 && k == 12) begin
                reset_i = 1'b1;
                run_active = 0;
                void'(exp_q.pop_back());
                hold_val = '0;
                #1;
                chk("rst_busy", 64'(bus.busy_o), 64'd0);
                chk("rst_done", 64'(bus.done_o), 64'd0);
                chk("rst_outputs", 64'(bus.outputs_o), 64'd0);
                @(posedge usb_clk); #1 reset_i = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [NI*8-1:0]    in;
        logic [NI*NO*8-1:0] w;
        logic [NO*8-1:0]    b;
        bus.start_i   = 1'b0;
        bus.inputs_i  = '0;
        bus.weights_i = '0;
        bus.bias_i    = '0;
        repeat (3) @(posedge usb_clk);
        #1;
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        chk("reset_done", 64'(bus.done_o), 64'd0);
        chk("reset_outputs", 64'(bus.outputs_o), 64'd0);
        chk("reset_trigger", 64'(bus.trigger_o), 64'd0);
        reset_i = 1'b0;
        repeat (2) @(posedge usb_clk);

        in = {NI{8'h10}};  w = {NI*NO{8'h10}}; b = '0;
        do_run(in, w, b, 3);
        chk("t1_value", 64'(bus.outputs_o), 64'h40404040);

        in = {NI{8'h01}};  w = {NI*NO{8'hFF}}; b = '0;
        do_run(in, w, b, 0);
        b = 32'h0010_0000;
        do_run(in, w, b, 0);
        chk("t2_value", 64'(bus.outputs_o), 64'h000F0000);

        in = {NI{8'h7F}};  w = {NI*NO{8'h7F}}; b = {NO{8'h7F}};
        do_run(in, w, b, 0);

        for (int n = 0; n < 4; n++) begin
            in = {$urandom, $urandom} >> 32;
            w  = {$urandom, $urandom, $urandom, $urandom};
            b  = $urandom;
            do_run(in, w, b, (n == 0) ? 1 : (n == 1) ? 2 : 0);
        end

        for (int n = 0; n < 15; n++) begin
            in = $urandom;
            w  = {$urandom, $urandom, $urandom, $urandom};
            b  = $urandom & 32'h1F1F_1F1F;
            do_run(in, w, b, 0);
        end

        repeat (5) @(posedge usb_clk);
        #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cw305_ml_sched.md
Name: cw305_ml_sched

Overview:
- Sequencer for the dense-layer ML datapath behind the CW305 ML register block.
- Takes a snapshot of the input, weight and bias register contents and shares one signed 8x8 multiplier across all products.
- For each output it computes the MAC, applies ReLU, scales and saturates, then publishes all outputs together.
- Start, busy and done handshake is driven from the register front end.

Parameters:
- pINPUTCNT, 4, number of 8-bit signed inputs per neuron.
- pOUTPUTCNT, 4, number of neurons / 8-bit outputs.
- pFRAC, 4, fractional bits; accumulator arithmetic right shift applied before saturation.

Ports:
- usb_clk  input  1  single clock for all logic.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle start pulse from the register block.
- inputs_i  input  pINPUTCNT*8  flat signed inputs; input i occupies bits [8i+7:8i].
- weights_i  input  pINPUTCNT*pOUTPUTCNT*8  flat signed weights; w[o][i] sits at index o*pINPUTCNT+i.
- bias_i  input  pOUTPUTCNT*8  flat signed biases, one per output.
- busy_o  output  1  high while a computation is in progress.
- done_o  output  1  one-cycle pulse when outputs_o is updated.
- outputs_o  output  pOUTPUTCNT*8  flat signed results, held between runs.
- trigger_o  output  1  SCA capture trigger (see Optional Feature).

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters and snapshot registers are 0.
- States and transitions:
  - IDLE: on start_i go to LOAD and capture inputs_i, weights_i and bias_i into snapshot registers on the same edge.
  - LOAD: acc = sign_extend(bias[o]) <<< pFRAC; i=0; go to MAC.
  - MAC: acc += in[i]*w[o][i] (one product per cycle). When i==pINPUTCNT-1 go to ACT, else i++.
  - ACT: r = acc >>> pFRAC; if r<0 then r=0; if r>127 then r=127. Write r into result shadow slot o. If o==pOUTPUTCNT-1 go to DONE, else o++ and go to LOAD.
  - DONE: copy shadow into outputs_o, pulse done_o for one cycle, return to IDLE.
- Accumulator width: 16+$clog2(pINPUTCNT)+pFRAC+1 bits, signed. No overflow is possible at any parameter value.
- Latency: start_i is sampled at edge 0. busy_o is high from edge 1 through the DONE cycle inclusive. done_o is high exactly in cycle pOUTPUTCNT*(pINPUTCNT+2)+1, which is 25 with the defaults. outputs_o changes on that same edge.
- start_i is ignored in every state except IDLE, including DONE. start_i in the same cycle as done_o is therefore ignored.
- Register-file writes while busy do not affect the current run, because it works only on the snapshot.
- outputs_o holds its last value until the next DONE. Partial results are never visible.
- reset_i asserted mid-run: immediate return to IDLE, all outputs 0, no done_o pulse.
- Counter o wraps to 0 only on the IDLE to LOAD transition. Counter i resets in every LOAD.

Optional Feature:
- Macro: CW305_ML_SCHED_TRIGGER_EN.
- Defined: trigger_o is registered high for every cycle spent in the MAC state across all neurons. It gives pOUTPUTCNT bursts of pINPUTCNT cycles for scope capture.
- Undefined: trigger_o is tied to 0 and the trigger logic is not synthesised. Functional results and latency are identical in both cases.

Test Plan:
1. All inputs 0x10, all weights 0x10, biases 0, pFRAC=4 -> each output = (4*256)>>4 = 64 (0x40). done_o pulses at cycle 25; busy_o is high for cycles 1-25.
2. Inputs 0x01, weights 0xFF (-1), bias 0 -> all outputs 0 (ReLU). Then bias[2]=0x10 with other settings unchanged -> output2 = (16*16-4)>>4 = 15 (0x0F), other outputs remain 0.
3. Inputs 0x7F, weights 0x7F, bias 0x7F -> every output saturates to 0x7F.
4. Second start_i at cycle 10 and weights_i changed at cycle 5 of a run -> no restart, done_o still at cycle 25, results computed from the start-time snapshot.
5. reset_i asserted at cycle 12 -> busy_o, outputs_o and done_o are 0 immediately. A fresh start_i then completes normally with done_o 25 cycles later.
6. With CW305_ML_SCHED_TRIGGER_EN: trigger_o is high for 4 bursts of 4 cycles, 16 cycles total per run. Without the macro: trigger_o stays 0 and outputs match the macro-enabled run.
